// File: rtl/rvseed_result_tx_pkg.sv
// Shared constants and message ROM for the rvseed end-of-test UART reporter.
package rvseed_result_tx_pkg;

  localparam int unsigned UART_CLK_DIV = 868;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_L  = 8'h4C;

  localparam logic [3:0] MSG_LEN_PASS = 4'd6;
  localparam logic [3:0] MSG_LEN_FAIL = 4'd9;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // "PASS\r\n" or "FAIL HH\r\n", indexed from the first character.
  function automatic logic [7:0] msg_byte(input logic pass, input logic [3:0] idx,
                                          input logic [7:0] num);
    logic [7:0] b;
    b = ASCII_LF;
    if (pass) begin
      case (idx)
        4'd0:    b = ASCII_P;
        4'd1:    b = ASCII_A;
        4'd2:    b = ASCII_S;
        4'd3:    b = ASCII_S;
        4'd4:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end else begin
      case (idx)
        4'd0:    b = ASCII_F;
        4'd1:    b = ASCII_A;
        4'd2:    b = ASCII_I;
        4'd3:    b = ASCII_L;
        4'd4:    b = ASCII_SP;
        4'd5:    b = hex_ascii(num[7:4]);
        4'd6:    b = hex_ascii(num[3:0]);
        4'd7:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/rvseed_result_tx_uart_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_byte
  import rvseed_result_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          wrap;

  assign wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != S_IDLE) begin
      baud_d = wrap ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (tx_start) begin
          state_d = S_START;
          shreg_d = tx_data;
          bit_d   = '0;
        end
      end
      S_START: if (wrap) state_d = S_DATA;
      S_DATA: begin
        if (wrap) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: if (wrap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = (state_q == S_STOP) && wrap;
  assign uart_tx = tx_q;

endmodule

// File: rtl/rvseed_result_tx.sv
// rvseed end-of-test reporter: on the end-flag rise, sends one PASS/FAIL line over UART.
module rvseed_result_tx
  import rvseed_result_tx_pkg::*;
#(
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned CLK_DIV   = UART_CLK_DIV,
  parameter int unsigned END_DLY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sim_end,
  input  logic                 sim_pass,
  input  logic [CPU_WIDTH-1:0] test_num,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [15:0] DLY_LAST = 16'(END_DLY - 1);

  logic [2:0]  state_q, state_d;
  logic        sim_end_q, sim_end_d;
  logic [15:0] dly_q, dly_d;
  logic        pass_q, pass_d;
  logic [7:0]  num_q, num_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_data;
  logic        unused_test_num_hi;

  assign unused_test_num_hi = ^test_num[CPU_WIDTH-1:8];
  assign tx_data = msg_byte(pass_q, idx_q, num_q);

  always_comb begin
    state_d   = state_q;
    sim_end_d = sim_end;
    dly_d     = dly_q;
    pass_d    = pass_q;
    num_d     = num_q;
    len_d     = len_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    tx_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sim_end && !sim_end_q) begin
          state_d = ST_DELAY;
          busy_d  = 1'b1;
          dly_d   = '0;
        end
      end
      ST_DELAY: begin
        if (dly_q == DLY_LAST) begin
          pass_d  = sim_pass;
          num_d   = test_num[7:0];
          len_d   = sim_pass ? MSG_LEN_PASS : MSG_LEN_FAIL;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      ST_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          if (idx_q == len_q - 4'd1) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sim_end_q <= 1'b0;
      dly_q     <= '0;
      pass_q    <= 1'b0;
      num_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sim_end_q <= sim_end_d;
      dly_q     <= dly_d;
      pass_q    <= pass_d;
      num_q     <= num_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_tx  (uart_tx)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_rvseed_result_tx.sv
// Directed bench for rvseed_result_tx: decodes the UART line and checks verdict text and timing.
module tb_rvseed_result_tx;

  localparam int CD = 4;
  localparam logic [71:0] MSG_PASS   = 72'h0A0D53534150;
  localparam logic [71:0] MSG_FAIL1A = 72'h0A0D4131204C494146;
  localparam logic [71:0] MSG_FAIL9F = 72'h0A0D4639204C494146;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        se1, sp1, tx1, busy1, done1;
  logic [31:0] tn1;
  logic        se3, sp3, tx3, busy3, done3;
  logic [31:0] tn3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvseed_result_tx #(.CPU_WIDTH(32), .CLK_DIV(CD), .END_DLY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sim_end(se1), .sim_pass(sp1), .test_num(tn1),
    .uart_tx(tx1), .busy(busy1), .done(done1)
  );

  rvseed_result_tx #(.CPU_WIDTH(32), .CLK_DIV(CD), .END_DLY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .sim_end(se3), .sim_pass(sp3), .test_num(tn3),
    .uart_tx(tx3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx3 : tx1;
  endfunction

  // Samples each bit near its middle, timed from the negedge that first sees the start bit.
  task automatic rx_byte(input bit sel, output logic [7:0] b);
    int t;
    t = 0;
    b = '0;
    @(negedge clk);
    while (line(sel) !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      check("rx_timeout", 32'd1, 32'd0);
      return;
    end
    repeat (2) @(negedge clk);
    check("rx_start", {31'd0, line(sel)}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CD) @(negedge clk);
      b[i] = line(sel);
    end
    repeat (CD) @(negedge clk);
    check("rx_stop", {31'd0, line(sel)}, 32'd1);
  endtask

  task automatic rx_msg(input bit sel, input string tag, input logic [71:0] exp, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      rx_byte(sel, b);
      check($sformatf("%s_b%0d", tag, i), {24'd0, b}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    se1 = 1'b0;
    se3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input string tag);
    int c;
    c = 0;
    while (done1 !== 1'b1 && c < 400) begin
      @(posedge clk);
      #1 c++;
    end
    check(tag, {31'd0, done1}, 32'd1);
  endtask

  initial begin
    int lat;
    int lows;
    rst_n = 1'b0;
    se1 = 1'b0; sp1 = 1'b0; tn1 = '0;
    se3 = 1'b0; sp3 = 1'b0; tn3 = '0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx1}, 32'd1);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_done", {31'd0, done1}, 32'd0);
    end
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy1}, 32'd0);

    // PASS message and end-to-done latency.
    sp1 = 1'b1;
    se1 = 1'b1;
    lat = 0;
    fork
      begin
        while (done1 !== 1'b1 && lat < 400) begin
          @(posedge clk);
          #1 lat++;
          if (lat == 1) check("busy_on", {31'd0, busy1}, 32'd1);
        end
        check("done_latency", lat, 248);
      end
      rx_msg(1'b0, "pass", MSG_PASS, 6);
    join
    check("pass_done", {31'd0, done1}, 32'd1);
    check("pass_busy_off", {31'd0, busy1}, 32'd0);
    check("pass_tx_idle", {31'd0, tx1}, 32'd1);

    // FAIL 1A with sim_end retoggled during and after the transmission.
    do_reset();
    sp1 = 1'b0;
    tn1 = 32'h0000011A;
    se1 = 1'b1;
    fork
      rx_msg(1'b0, "fail1a", MSG_FAIL1A, 9);
      begin
        repeat (60) @(posedge clk);
        #1 se1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 se1 = 1'b1;
      end
    join
    wait_done1("fail_done");
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx1 === 1'b0) lows++;
      if (i == 20) se1 = 1'b0;
      if (i == 30) se1 = 1'b1;
    end
    check("no_resend", lows, 0);
    check("done_sticky", {31'd0, done1}, 32'd1);

    // Reset in the middle of byte 2's data bits, then a full resend.
    do_reset();
    sp1 = 1'b1;
    se1 = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy1}, 32'd1);
    check("mid_tx_low", {31'd0, tx1}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx", {31'd0, tx1}, 32'd1);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_done", {31'd0, done1}, 32'd0);
    se1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 se1 = 1'b1;
    rx_msg(1'b0, "resend", MSG_PASS, 6);
    wait_done1("resend_done");

    // END_DLY=3: pass sampled three clocks after the edge is registered.
    do_reset();
    sp3 = 1'b0;
    tn3 = 32'h0000009F;
    se3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 sp3 = 1'b1;
    rx_msg(1'b1, "dly_pass", MSG_PASS, 6);

    do_reset();
    sp3 = 1'b0;
    tn3 = 32'hABCD129F;
    se3 = 1'b1;
    repeat (4) @(posedge clk);
    #1 sp3 = 1'b1;
    rx_msg(1'b1, "dly_fail", MSG_FAIL9F, 9);
    repeat (2 * CD) @(posedge clk);
    #1;
    check("dly_done", {31'd0, done3}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
